// File: rtl/spi_slave.sv
// SPI slave front-end for a RAM: receives 10-bit command/payload frames on MOSI
// and, for read-data commands, returns the RAM byte on MISO MSB first.
module spi_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  count_reg;
    logic [8:0]  shift_reg;
    logic [9:0]  rx_data_reg;
    logic        rx_valid_reg;
    logic        miso_reg;
    logic        rd_addr_seen_reg;
    logic [7:0]  tx_byte_reg;
    logic        latched_reg;
    logic        shifting_reg;
    logic [2:0]  miso_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == IDLE) begin
            if (!SS_n) begin
                state_next = CHK_CMD;
            end
        end else if (SS_n) begin
            state_next = IDLE;
        end else if (state_reg == CHK_CMD) begin
            if (!MOSI) begin
                state_next = WRITE;
            end else if (rd_addr_seen_reg) begin
                state_next = READ_DATA;
            end else begin
                state_next = READ_ADD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg        <= 4'd0;
            shift_reg        <= 9'd0;
            rx_data_reg      <= 10'h000;
            rx_valid_reg     <= 1'b0;
            miso_reg         <= 1'b0;
            rd_addr_seen_reg <= 1'b0;
            tx_byte_reg      <= 8'd0;
            latched_reg      <= 1'b0;
            shifting_reg     <= 1'b0;
            miso_cnt_reg     <= 3'd0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (state_reg == IDLE || SS_n) begin
                // An abort right after bit0 finished still counts as a completed read.
                if (shifting_reg && miso_cnt_reg == 3'd0) begin
                    rd_addr_seen_reg <= 1'b0;
                end
                count_reg    <= 4'd0;
                latched_reg  <= 1'b0;
                shifting_reg <= 1'b0;
                miso_cnt_reg <= 3'd0;
                miso_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    CHK_CMD: begin
                        shift_reg <= {8'd0, MOSI};
                        count_reg <= 4'd1;
                    end
                    default: begin
                        if (count_reg < 4'd10) begin
                            shift_reg <= {shift_reg[7:0], MOSI};
                            count_reg <= count_reg + 4'd1;
                            if (count_reg == 4'd9) begin
                                rx_data_reg  <= {shift_reg, MOSI};
                                rx_valid_reg <= 1'b1;
                                if (state_reg == READ_ADD) begin
                                    rd_addr_seen_reg <= 1'b1;
                                end
                            end
                        end else if (state_reg == READ_DATA) begin
                            if (!latched_reg) begin
                                if (tx_valid) begin
                                    tx_byte_reg  <= tx_data;
                                    latched_reg  <= 1'b1;
                                    shifting_reg <= 1'b1;
                                    miso_reg     <= tx_data[7];
                                    miso_cnt_reg <= 3'd7;
                                end
                            end else if (shifting_reg) begin
                                if (miso_cnt_reg != 3'd0) begin
                                    miso_reg     <= tx_byte_reg[miso_cnt_reg - 3'd1];
                                    miso_cnt_reg <= miso_cnt_reg - 3'd1;
                                end else begin
                                    miso_reg         <= 1'b0;
                                    shifting_reg     <= 1'b0;
                                    rd_addr_seen_reg <= 1'b0;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign MISO     = miso_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives inputs on the falling edge and checks
// outputs on the falling edge, i.e. half a cycle after the active edge.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int rv_cnt    = 0;
    int c0;
    logic [7:0] exp_byte;

    spi_slave dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid === 1'b1) rv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [9:0] f, input int n);
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MOSI = f[9-i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_rxvalid", 32'(rx_valid), 32'd0);
        check("rst_rxdata", 32'(rx_data), 32'h000);
        rst = 1'b0;
        @(negedge clk);

        // Write address; extra MOSI bits after the frame must be ignored.
        c0 = rv_cnt;
        send(10'h005, 10);
        @(negedge clk);
        check("wa_rxvalid", 32'(rx_valid), 32'd1);
        check("wa_rxdata", 32'(rx_data), 32'h005);
        check("wa_miso", 32'(MISO), 32'd0);
        MOSI = 1'b1;
        @(negedge clk);
        check("wa_rxv_low", 32'(rx_valid), 32'd0);
        MOSI = 1'b0;
        @(negedge clk);
        check("wa_pulses", 32'(rv_cnt - c0), 32'd1);
        check("wa_hold", 32'(rx_data), 32'h005);
        end_frame();

        // Write data
        send(10'h1AA, 10);
        @(negedge clk);
        check("wd_rxvalid", 32'(rx_valid), 32'd1);
        check("wd_rxdata", 32'(rx_data), 32'h1AA);
        @(negedge clk);
        check("wd_rxv_low", 32'(rx_valid), 32'd0);
        end_frame();

        // Read address
        send(10'h205, 10);
        @(negedge clk);
        check("ra_rxdata", 32'(rx_data), 32'h205);
        check("ra_seen", 32'(dut.rd_addr_seen_reg), 32'd1);
        end_frame();

        // Read data: RAM answers one cycle after rx_valid; a second tx_valid is ignored
        send(10'h3C5, 10);
        @(negedge clk);
        check("rd_rxvalid", 32'(rx_valid), 32'd1);
        check("rd_rxdata", 32'(rx_data), 32'h3C5);
        check("rd_miso_idle", 32'(MISO), 32'd0);
        @(negedge clk);
        check("rd_rxv_low", 32'(rx_valid), 32'd0);
        tx_valid = 1'b1; tx_data = 8'hAA;
        exp_byte = 8'hAA;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rd_miso_b%0d", 7 - k), 32'(MISO), 32'(exp_byte[7-k]));
            tx_valid = (k == 2);
            tx_data  = (k == 2) ? 8'h55 : 8'h00;
        end
        @(negedge clk);
        check("rd_miso_after", 32'(MISO), 32'd0);
        check("rd_seen_clr", 32'(dut.rd_addr_seen_reg), 32'd0);
        @(negedge clk);
        check("rd_miso_hold0", 32'(MISO), 32'd0);
        end_frame();

        // Abort after 6 bits, then a full frame
        c0 = rv_cnt;
        send(10'h3FF, 6);
        @(negedge clk);
        SS_n = 1'b1;
        @(negedge clk);
        check("ab_state_idle", 32'(dut.state_reg), 32'd0);
        @(negedge clk);
        check("ab_no_pulse", 32'(rv_cnt - c0), 32'd0);
        check("ab_seen_kept", 32'(dut.rd_addr_seen_reg), 32'd0);
        send(10'h0F0, 10);
        @(negedge clk);
        check("ab_next_rxv", 32'(rx_valid), 32'd1);
        check("ab_next_data", 32'(rx_data), 32'h0F0);
        end_frame();

        // Reset during the MISO shift
        send(10'h205, 10);
        end_frame();
        send(10'h300, 10);
        @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hF0;
        @(negedge clk);
        tx_valid = 1'b0;
        check("rs_miso_b7", 32'(MISO), 32'd1);
        @(negedge clk);
        check("rs_miso_b6", 32'(MISO), 32'd1);
        rst = 1'b1; SS_n = 1'b1;
        @(negedge clk);
        check("rs_miso", 32'(MISO), 32'd0);
        check("rs_rxvalid", 32'(rx_valid), 32'd0);
        check("rs_seen", 32'(dut.rd_addr_seen_reg), 32'd0);
        check("rs_rxdata", 32'(rx_data), 32'h000);
        rst = 1'b0;
        send(10'h300, 10);
        @(negedge clk);
        check("rs_rxvalid2", 32'(rx_valid), 32'd1);
        check("rs_rxdata2", 32'(rx_data), 32'h300);
        check("rs_state_ra", 32'(dut.state_reg), 32'd3);
        check("rs_seen2", 32'(dut.rd_addr_seen_reg), 32'd1);
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rs_miso_q%0d", k), 32'(MISO), 32'd0);
        end
        end_frame();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
